// File: rtl/camellia_f_sbox_seq.sv
// Camellia F-function S-layer: eight byte lookups through one shared dual-port SBOX_1,
// two bytes per cycle, with s2/s3/s4 derived from s1 by rotating data or address.
module camellia_f_sbox_seq #(
   parameter int ROM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   localparam int unsigned SBOX1 [256] = '{
      112,130, 44,236,179, 39,192,229,228,133, 87, 53,234, 12,174, 65,
       35,239,107,147, 69, 25,165, 33,237, 14, 79, 78, 29,101,146,189,
      134,184,175,143,124,235, 31,206, 62, 48,220, 95, 94,197, 11, 26,
      166,225, 57,202,213, 71, 93, 61,217,  1, 90,214, 81, 86,108, 77,
      139, 13,154,102,251,204,176, 45,116, 18, 43, 32,240,177,132,153,
      223, 76,203,194, 52,126,118,  5,109,183,169, 49,209, 23,  4,215,
       20, 88, 58, 97,222, 27, 17, 28, 50, 15,156, 22, 83, 24,242, 34,
      254, 68,207,178,195,181,122,145, 36,  8,232,168, 96,252,105, 80,
      170,208,160,125,161,137, 98,151, 84, 91, 30,149,224,255,100,210,
       16,196,  0, 72,163,247,117,219,138,  3,230,218,  9, 63,221,148,
      135, 92,131,  2,205, 74,144, 51,115,103,246,243,157,127,191,226,
       82,155,216, 38,200, 55,198, 59,129,150,111, 75, 19,190, 99, 46,
      233,121,167,140,159,110,188,142, 41,245,249,182, 47,253,180, 89,
      120,152,  6,106,231, 70,113,186,212, 37,171, 66,136,162,141,250,
      114,  7,185, 85,248,238,172, 10, 54, 73, 42,104, 60, 56,241,164,
       64, 40,211,123,187,201, 67,193, 21,227,173,244,119,199,128,158
   };

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_cnt;
   logic [63:0] r_in, r_out;
   logic [7:0]  r_douta [ROM_LAT];
   logic [7:0]  r_doutb [ROM_LAT];
   logic [7:0]  w_addra, w_addrb, w_ya, w_yb;
   logic [1:0]  w_cap_pair;
   logic        w_accept, w_capture, w_last;

   assign in_ready   = (r_state == ST_IDLE) && rst_n;
   assign out_valid  = (r_state == ST_DONE);
   assign busy       = (r_state == ST_RUN) || (r_state == ST_DONE);
   assign out_data   = r_out;
   assign w_accept   = in_valid && in_ready;
   assign w_capture  = (r_state == ST_RUN) && (r_cnt >= 3'(ROM_LAT));
   assign w_cap_pair = 2'(r_cnt - 3'(ROM_LAT));
   assign w_last     = w_capture && (w_cap_pair == 2'd3);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_addra = 8'h00;
      w_addrb = 8'h00;
      if (r_state == ST_RUN && r_cnt <= 3'd3) begin
         case (r_cnt[1:0])
            2'd0: begin w_addra = r_in[63:56]; w_addrb = r_in[7:0];   end
            2'd1: begin w_addra = r_in[55:48]; w_addrb = r_in[31:24]; end
            2'd2: begin w_addra = r_in[47:40]; w_addrb = r_in[23:16]; end
            default: begin
               // s4 rotates the address rather than the looked-up byte
               w_addra = {r_in[38:32], r_in[39]};
               w_addrb = {r_in[14:8], r_in[15]};
            end
         endcase
      end
   end

   always_comb begin
      w_ya = r_douta[ROM_LAT-1];
      w_yb = r_doutb[ROM_LAT-1];
      case (w_cap_pair)
         2'd1: begin w_ya = {w_ya[6:0], w_ya[7]}; w_yb = {w_yb[6:0], w_yb[7]}; end
         2'd2: begin w_ya = {w_ya[0], w_ya[7:1]}; w_yb = {w_yb[0], w_yb[7:1]}; end
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)  w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
         ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 3'd0;
         r_in  <= 64'h0;
         r_out <= 64'h0;
      end else begin
         if (w_accept) begin
            r_in  <= in_data;
            r_cnt <= 3'd0;
         end else if (r_state == ST_RUN && !w_last) begin
            r_cnt <= r_cnt + 3'd1;
         end
         if (w_capture) begin
            case (w_cap_pair)
               2'd0: begin r_out[63:56] <= w_ya; r_out[7:0]   <= w_yb; end
               2'd1: begin r_out[55:48] <= w_ya; r_out[31:24] <= w_yb; end
               2'd2: begin r_out[47:40] <= w_ya; r_out[23:16] <= w_yb; end
               default: begin r_out[39:32] <= w_ya; r_out[15:8] <= w_yb; end
            endcase
         end
      end
   end

   // NOTE: the SBOX table is constant and needs no reset; only the read pipeline registers are reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ROM_LAT; i++) begin
            r_douta[i] <= 8'h00;
            r_doutb[i] <= 8'h00;
         end
      end else begin
         r_douta[0] <= 8'(SBOX1[w_addra]);
         r_doutb[0] <= 8'(SBOX1[w_addrb]);
         for (int i = 1; i < ROM_LAT; i++) begin
            r_douta[i] <= r_douta[i-1];
            r_doutb[i] <= r_doutb[i-1];
         end
      end
   end

endmodule

// File: tb/tb_camellia_f_sbox_seq.sv
// Bench for camellia_f_sbox_seq: directed vectors, backpressure, back-to-back random words,
// mid-run reset, and a ROM_LAT=2 instance, all against a byte-level S-function model.
module tb_camellia_f_sbox_seq;

   localparam int unsigned SBOX1 [256] = '{
      112,130, 44,236,179, 39,192,229,228,133, 87, 53,234, 12,174, 65,
       35,239,107,147, 69, 25,165, 33,237, 14, 79, 78, 29,101,146,189,
      134,184,175,143,124,235, 31,206, 62, 48,220, 95, 94,197, 11, 26,
      166,225, 57,202,213, 71, 93, 61,217,  1, 90,214, 81, 86,108, 77,
      139, 13,154,102,251,204,176, 45,116, 18, 43, 32,240,177,132,153,
      223, 76,203,194, 52,126,118,  5,109,183,169, 49,209, 23,  4,215,
       20, 88, 58, 97,222, 27, 17, 28, 50, 15,156, 22, 83, 24,242, 34,
      254, 68,207,178,195,181,122,145, 36,  8,232,168, 96,252,105, 80,
      170,208,160,125,161,137, 98,151, 84, 91, 30,149,224,255,100,210,
       16,196,  0, 72,163,247,117,219,138,  3,230,218,  9, 63,221,148,
      135, 92,131,  2,205, 74,144, 51,115,103,246,243,157,127,191,226,
       82,155,216, 38,200, 55,198, 59,129,150,111, 75, 19,190, 99, 46,
      233,121,167,140,159,110,188,142, 41,245,249,182, 47,253,180, 89,
      120,152,  6,106,231, 70,113,186,212, 37,171, 66,136,162,141,250,
      114,  7,185, 85,248,238,172, 10, 54, 73, 42,104, 60, 56,241,164,
       64, 40,211,123,187,201, 67,193, 21,227,173,244,119,199,128,158
   };

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, out_ready, in_ready, out_valid, busy;
   logic [63:0] in_data, out_data;
   logic        in_valid2, out_ready2, in_ready2, out_valid2, busy2;
   logic [63:0] in_data2, out_data2;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   camellia_f_sbox_seq #(.ROM_LAT(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

   camellia_f_sbox_seq #(.ROM_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .busy(busy2));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] s1(input logic [7:0] x);
      return 8'(SBOX1[x]);
   endfunction

   function automatic logic [7:0] rotl1(input logic [7:0] x);
      return 8'((x << 1) | (x >> 7));
   endfunction

   function automatic logic [7:0] rotr1(input logic [7:0] x);
      return 8'((x >> 1) | (x << 7));
   endfunction

   // y1..y8 from t1..t8 using the s-type assigned to each byte position
   function automatic logic [63:0] model(input logic [63:0] x);
      logic [7:0] t [8];
      logic [7:0] y [8];
      for (int i = 0; i < 8; i++) t[i] = x[63-8*i -: 8];
      y[0] = s1(t[0]);         y[7] = s1(t[7]);
      y[1] = rotl1(s1(t[1]));  y[4] = rotl1(s1(t[4]));
      y[2] = rotr1(s1(t[2]));  y[5] = rotr1(s1(t[5]));
      y[3] = s1(rotl1(t[3]));  y[6] = s1(rotl1(t[6]));
      return {y[0], y[1], y[2], y[3], y[4], y[5], y[6], y[7]};
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_word(input string tag, input logic [63:0] d, input logic [63:0] exp);
      int lat;
      check({tag, "_ready"}, 64'(in_ready), 64'd1);
      in_data  = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_data  = rnd64();
      check({tag, "_busy"}, 64'(busy), 64'd1);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'd5);
      check({tag, "_data"}, out_data, exp);
      tick();
      check({tag, "_idle"}, 64'({out_valid, in_ready, busy}), 64'b010);
   endtask

   task automatic run_word2(input string tag, input logic [63:0] d, input logic [63:0] exp);
      int lat;
      in_data2  = d;
      in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      lat = 0;
      while (!out_valid2 && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'd6);
      check({tag, "_data"}, out_data2, exp);
      tick();
   endtask

   task automatic backpressure();
      logic [63:0] d, held;
      logic        stable;
      int          lat;
      d         = rnd64();
      out_ready = 1'b0;
      in_data   = d;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("bp_data", out_data, model(d));
      held   = out_data;
      stable = 1'b1;
      repeat (10) begin
         tick();
         if (!out_valid || out_data !== held || in_ready || !busy) stable = 1'b0;
      end
      check("bp_stable", 64'(stable), 64'd1);
      out_ready = 1'b1;
      tick();
      check("bp_release_valid", 64'(out_valid), 64'd0);
      check("bp_release_ready", 64'(in_ready), 64'd1);
   endtask

   task automatic back_to_back(input int n_words);
      logic [63:0] q[$];
      logic        acc, deq, extra;
      int          cyc, last, n_acc, n_out;
      cyc = 0; last = -1; n_acc = 0; n_out = 0;
      in_data  = rnd64();
      in_valid = 1'b1;
      while (n_out < n_words && cyc < 400) begin
         acc = in_valid && in_ready;
         deq = out_valid && out_ready;
         if (deq) begin
            if (q.size() == 0) check("b2b_unexpected", out_data, 64'hX);
            else               check("b2b_data", out_data, q.pop_front());
            n_out++;
         end
         tick();
         cyc++;
         if (acc) begin
            q.push_back(model(in_data));
            if (last >= 0) check("b2b_interval", 64'(cyc - last), 64'd7);
            last = cyc;
            n_acc++;
            if (n_acc == n_words) in_valid = 1'b0;
            else                  in_data  = rnd64();
         end
      end
      check("b2b_count", 64'(n_out), 64'(n_words));
      check("b2b_pending", 64'(q.size()), 64'd0);
      extra = 1'b0;
      repeat (10) begin
         tick();
         if (out_valid) extra = 1'b1;
      end
      check("b2b_no_extra", 64'(extra), 64'd0);
   endtask

   task automatic reset_mid_run();
      logic seen;
      in_data  = rnd64();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("rst_outputs", 64'({in_ready, out_valid, busy}), 64'b000);
      check("rst_data", out_data, 64'h0);
      #2 rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      check("rst_no_output", 64'(seen), 64'd0);
   endtask

   initial begin
      logic [63:0] d;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_data    = 64'h0;
      out_ready  = 1'b1;
      in_valid2  = 1'b0;
      in_data2   = 64'h0;
      out_ready2 = 1'b1;
      #12;
      check("reset_in_ready", 64'(in_ready), 64'd0);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_data", out_data, 64'h0);
      check("reset_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      tick();
      check("idle_in_ready", 64'(in_ready), 64'd1);

      run_word("zero", 64'h0, 64'h70E03870E0387070);
      run_word("ones", 64'hFFFFFFFFFFFFFFFF, 64'h9E3D4F9E3D4F9E9E);
      run_word("x01", 64'h0101010101010101, 64'h8205412C05412C82);
      for (int i = 0; i < 6; i++) begin
         d = rnd64();
         run_word("rand", d, model(d));
      end

      backpressure();
      back_to_back(8);
      reset_mid_run();
      d = rnd64();
      run_word("after_rst", d, model(d));

      run_word2("lat2_zero", 64'h0, 64'h70E03870E0387070);
      run_word2("lat2_ones", 64'hFFFFFFFFFFFFFFFF, 64'h9E3D4F9E3D4F9E9E);
      d = rnd64();
      run_word2("lat2_rand", d, model(d));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
